// File: rtl/pwm_meas.sv
// PWM capture: measures high time and rise-to-rise period in clk cycles, with a sticky stuck-input timeout.
// Optional PWM_MEAS_AVG_EN reports the floor average of every 4 consecutive periods instead of each period.
module pwm_meas #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 200_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             en,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic             stuck_level_q, stuck_level_d;
  logic             rise, fall, tmo_fire, period_done;

`ifdef PWM_MEAS_AVG_EN
  logic [1:0]       acc_n_q, acc_n_d;
  logic [CNT_W+1:0] sum_h_q, sum_h_d, sum_p_q, sum_p_d;
  logic [CNT_W+1:0] sum_h_nx, sum_p_nx;
`endif

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    pcnt_d        = pcnt_q;
    high_cnt_d    = high_cnt_q;
    period_cnt_d  = period_cnt_q;
    meas_valid_d  = 1'b0;
    timeout_d     = timeout_q;
    stuck_level_d = stuck_level_q;
    tmo_fire      = 1'b0;
    period_done   = 1'b0;

    if (!en) begin
      state_d = IDLE;
      hcnt_d  = '0;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          hcnt_d  = '0;
          pcnt_d  = '0;
          state_d = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            hcnt_d  = ONE;
            pcnt_d  = ONE;
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (pcnt_q == TMO) begin
            tmo_fire = 1'b1;
          end else if (fall) begin
            pcnt_d  = pcnt_q + ONE;
            state_d = LOW;
          end else begin
            hcnt_d = hcnt_q + ONE;
            pcnt_d = pcnt_q + ONE;
          end
        end
        LOW: begin
          // a rise landing on the threshold cycle wins over the timeout
          if (rise) begin
            period_done = 1'b1;
            hcnt_d      = ONE;
            pcnt_d      = ONE;
            state_d     = HIGH;
          end else if (pcnt_q == TMO) begin
            tmo_fire = 1'b1;
          end else begin
            pcnt_d = pcnt_q + ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (tmo_fire) begin
      timeout_d     = 1'b1;
      stuck_level_d = s2_q;
      high_cnt_d    = '0;
      period_cnt_d  = '0;
      hcnt_d        = '0;
      pcnt_d        = '0;
      state_d       = WAIT_RISE;
    end

`ifdef PWM_MEAS_AVG_EN
    sum_h_nx = sum_h_q + {2'b00, hcnt_q};
    sum_p_nx = sum_p_q + {2'b00, pcnt_q};
    acc_n_d  = acc_n_q;
    sum_h_d  = sum_h_q;
    sum_p_d  = sum_p_q;
    if (!en || tmo_fire) begin
      acc_n_d = '0;
      sum_h_d = '0;
      sum_p_d = '0;
    end else if (period_done) begin
      if (acc_n_q == 2'd3) begin
        high_cnt_d   = sum_h_nx[CNT_W+1:2];
        period_cnt_d = sum_p_nx[CNT_W+1:2];
        meas_valid_d = 1'b1;
        timeout_d    = 1'b0;
        acc_n_d      = '0;
        sum_h_d      = '0;
        sum_p_d      = '0;
      end else begin
        acc_n_d = acc_n_q + 2'd1;
        sum_h_d = sum_h_nx;
        sum_p_d = sum_p_nx;
      end
    end
`else
    if (period_done) begin
      high_cnt_d   = hcnt_q;
      period_cnt_d = pcnt_q;
      meas_valid_d = 1'b1;
      timeout_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      hcnt_q        <= '0;
      pcnt_q        <= '0;
      high_cnt_q    <= '0;
      period_cnt_q  <= '0;
      meas_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
      stuck_level_q <= 1'b0;
`ifdef PWM_MEAS_AVG_EN
      acc_n_q       <= '0;
      sum_h_q       <= '0;
      sum_p_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      s1_q          <= pwm_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      hcnt_q        <= hcnt_d;
      pcnt_q        <= pcnt_d;
      high_cnt_q    <= high_cnt_d;
      period_cnt_q  <= period_cnt_d;
      meas_valid_q  <= meas_valid_d;
      timeout_q     <= timeout_d;
      stuck_level_q <= stuck_level_d;
`ifdef PWM_MEAS_AVG_EN
      acc_n_q       <= acc_n_d;
      sum_h_q       <= sum_h_d;
      sum_p_q       <= sum_p_d;
`endif
    end
  end

  assign high_cnt    = high_cnt_q;
  assign period_cnt  = period_cnt_q;
  assign meas_valid  = meas_valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Randomized bench for pwm_meas: a period-level model predicts each strobe's high/period values.
// Model follows PWM_MEAS_AVG_EN when defined (4-period floor averages).
module tb_pwm_meas;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic             en = 1'b0;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic             meas_valid, timeout, stuck_level;

  pwm_meas #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .en(en),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .meas_valid(meas_valid),
    .timeout(timeout), .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned h;
    int unsigned p;
  } meas_t;

  int          n_chk = 0;
  int          n_bad = 0;
  meas_t       exp_q[$];
  meas_t       mon_m;
  bit          have_prev = 1'b0;
  int unsigned prev_h, prev_p;
  int unsigned last_h = 0, last_p = 0;
  bit          exp_to = 1'b0, exp_stuck = 1'b0;
  int unsigned grp_n = 0, grp_h = 0, grp_p = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void push_meas(input int unsigned h, input int unsigned p);
    meas_t m;
    m.h = h;
    m.p = p;
    exp_q.push_back(m);
    last_h = h;
    last_p = p;
    exp_to = 1'b0;
  endfunction

  function automatic void emit(input int unsigned h, input int unsigned p);
`ifdef PWM_MEAS_AVG_EN
    grp_h += h;
    grp_p += p;
    grp_n++;
    if (grp_n == 4) begin
      push_meas(grp_h / 4, grp_p / 4);
      grp_n = 0;
      grp_h = 0;
      grp_p = 0;
    end
`else
    push_meas(h, p);
`endif
  endfunction

  function automatic void model_break();
    have_prev = 1'b0;
    grp_n = 0;
    grp_h = 0;
    grp_p = 0;
  endfunction

  // A rise closes the previous period; a period longer than TIMEOUT is lost to the timeout.
  function automatic void model_rise(input int unsigned h, input int unsigned l);
    if (have_prev) emit(prev_h, prev_p);
    prev_h    = h;
    prev_p    = h + l;
    have_prev = 1'b1;
    if (h + l > TIMEOUT) begin
      model_break();
      last_h    = 0;
      last_p    = 0;
      exp_to    = 1'b1;
      exp_stuck = (h > TIMEOUT);
    end
  endfunction

  task automatic cycles(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_period(input int unsigned h, input int unsigned l);
    model_rise(h, l);
    pwm_in = 1'b1;
    cycles(h);
    pwm_in = 1'b0;
    cycles(l);
  endtask

  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", meas_valid, 0);
      end else begin
        mon_m = exp_q.pop_front();
        check("high_cnt", high_cnt, mon_m.h);
        check("period_cnt", period_cnt, mon_m.p);
        check("timeout_at_strobe", timeout, 0);
      end
    end
  end

  initial begin
    cycles(3);
    check("rst_high_cnt", high_cnt, 0);
    check("rst_period_cnt", period_cnt, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_stuck_level", stuck_level, 0);
    rst_n = 1'b1;
    cycles(2);
    en = 1'b1;
    cycles(3);

    repeat (5) drive_period(30, 70);
    check("steady_high", high_cnt, last_h);
    check("steady_period", period_cnt, last_p);

    repeat (3) drive_period(50, 50);

    repeat (40) drive_period($urandom_range(1, 60), $urandom_range(1, 60));
    repeat (3) drive_period(1, 1);

    drive_period(10, TIMEOUT - 10);
    drive_period(1, 1);
    drive_period(5, 5);
    check("threshold_rise_no_timeout", timeout, exp_to);

    drive_period(TIMEOUT + 30, 70);
    check("stuck_hi_timeout", timeout, exp_to);
    check("stuck_hi_level", stuck_level, exp_stuck);
    check("stuck_hi_high", high_cnt, last_h);
    check("stuck_hi_period", period_cnt, last_p);
    drive_period(30, 70);
    check("timeout_sticky", timeout, exp_to);
    repeat (2) drive_period(30, 70);
    check("timeout_recover", timeout, exp_to);

    drive_period(10, TIMEOUT + 20);
    check("stuck_lo_timeout", timeout, exp_to);
    check("stuck_lo_level", stuck_level, exp_stuck);
    check("stuck_lo_period", period_cnt, last_p);
    repeat (6) drive_period($urandom_range(5, 60), $urandom_range(5, 60));
    check("stuck_lo_recover", timeout, exp_to);

    model_rise(60, 40);
    pwm_in = 1'b1;
    cycles(10);
    en = 1'b0;
    cycles(10);
    check("en_low_high_hold", high_cnt, last_h);
    check("en_low_period_hold", period_cnt, last_p);
    check("en_low_timeout_hold", timeout, exp_to);
    en = 1'b1;
    cycles(40);
    pwm_in = 1'b0;
    cycles(40);
    model_break();
    repeat (6) drive_period(30, 70);

    model_rise(30, 70);
    pwm_in = 1'b1;
    cycles(30);
    pwm_in = 1'b0;
    cycles(20);
    rst_n = 1'b0;
    #1;
    check("midrst_high_cnt", high_cnt, 0);
    check("midrst_period_cnt", period_cnt, 0);
    check("midrst_meas_valid", meas_valid, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_stuck_level", stuck_level, 0);
    cycles(1);
    rst_n = 1'b1;
    model_break();
    last_h    = 0;
    last_p    = 0;
    exp_to    = 1'b0;
    exp_stuck = 1'b0;
    cycles(50);

    drive_period(40, 60);
    drive_period(40, 60);
    drive_period(42, 62);
    drive_period(42, 62);
    drive_period(30, 70);
    check("avg_seq_high", high_cnt, last_h);
    check("avg_seq_period", period_cnt, last_p);

    cycles(10);
    check("all_strobes_seen", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
